bit_plane_serializer: RTL and testbench

BIT_PLANE_SERIALIZER -- requirements
Module: bit_plane_serializer

---
 rtl/smac_pkg.sv | 24 ++
 rtl/bit_plane_serializer.sv | 129 ++++++++++++
 tb/tb_bit_plane_serializer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/smac_pkg.sv
// Shared definitions for the SMAC (serial multiply-accumulate) blocks:
// default lane/word geometry, the serializer FSM state type and a small
// helper for sizing column counters.
package smac_pkg;

    // Default number of lanes (words per block, column width)
    localparam int SMAC_M = 16;

    // Default word width in bits (columns per block)
    localparam int SMAC_N = 8;

    // Serializer FSM states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } smac_state_t;

    // Width of a column-index counter for n columns; never less than one bit
    // so a single-column configuration still has a legal register.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_plane_serializer.sv
// Bit-plane serializer: captures a block of M signed N-bit words and emits it
// as N bit columns, sign column first, down to bit 0. Each column carries bit
// j of every word, one lane per word, so a downstream shift-accumulate with a
// popcount per column rebuilds the sum of the words.
module bit_plane_serializer
    import smac_pkg::*;
#(
    parameter int M = SMAC_M,
    parameter int N = SMAC_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           blk_valid,
    output logic           blk_ready,
    input  logic [M*N-1:0] blk_data,
    output logic           col_valid,
    input  logic           col_ready,
    output logic [M-1:0]   col_data,
    output logic           col_msb,
    output logic           col_last
);

    localparam int            CW       = cnt_width(N);
    localparam logic [CW-1:0] CNT_TOP  = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    smac_state_t         state_r;
    smac_state_t         state_next_s;
    logic [M-1:0][N-1:0] hold_r;
    logic [CW-1:0]       cnt_r;
    logic                accept_s;
    logic                xfer_s;
    logic                at_last_s;
    logic                at_msb_s;

    // Column position flags and handshake qualifiers
    assign at_last_s = (cnt_r == CNT_ZERO);
    assign at_msb_s  = (cnt_r == CNT_TOP);
    assign xfer_s    = col_valid && col_ready;
    assign accept_s  = blk_valid && blk_ready;

    // FSM state register; reset discards any block in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: stay in SHIFT across a last-column transfer that
    // coincides with a new block so blocks stream without a bubble
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (xfer_s && at_last_s && !accept_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM outputs: column mux on the holding register, flags from the counter;
    // everything is quiet in IDLE and blk_ready is held low during reset
    always_comb begin
        col_valid = 1'b0;
        col_msb   = 1'b0;
        col_last  = 1'b0;
        col_data  = {M{1'b0}};
        blk_ready = 1'b0;
        case (state_r)
            IDLE: begin
                blk_ready = rst_n;
            end
            SHIFT: begin
                col_valid = 1'b1;
                col_msb   = at_msb_s;
                col_last  = at_last_s;
                blk_ready = rst_n && at_last_s && col_ready;
                for (int i = 0; i < M; i++) begin
                    col_data[i] = hold_r[i][cnt_r];
                end
            end
            default: begin
                blk_ready = 1'b0;
            end
        endcase
    end

    // Holding register: captures the whole block on acceptance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_r <= '0;
        end else if (accept_s) begin
            hold_r <= blk_data;
        end else begin
            hold_r <= hold_r;
        end
    end

    // Column index: loads the sign column on acceptance, steps down on each
    // transfer and parks at zero instead of wrapping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (accept_s) begin
            cnt_r <= CNT_TOP;
        end else if (xfer_s && !at_last_s) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: tb/tb_bit_plane_serializer.sv
// Directed and random bench for bit_plane_serializer. Accepted blocks push
// their expected columns and word sum into scoreboards; every column transfer
// pops and compares, and a shift-accumulate over the observed columns is
// checked against the expected sum at the end of each block.
module tb_bit_plane_serializer;
    import smac_pkg::*;

    localparam int M = SMAC_M;
    localparam int N = SMAC_N;

    typedef struct {
        logic [M-1:0] data;
        logic         msb;
        logic         last;
        int           idx;
    } col_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           blk_valid;
    logic           blk_ready;
    logic [M*N-1:0] blk_data;
    logic           col_valid;
    logic           col_ready;
    logic [M-1:0]   col_data;
    logic           col_msb;
    logic           col_last;

    int   n_checks = 0;
    int   n_fail   = 0;
    col_t sb[$];
    int   sum_q[$];
    int   acc      = 0;
    int   last_idx = -1;
    logic accepted = 1'b0;

    always #5 clk = ~clk;

    bit_plane_serializer #(.M(M), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .col_valid (col_valid),
        .col_ready (col_ready),
        .col_data  (col_data),
        .col_msb   (col_msb),
        .col_last  (col_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [M-1:0] exp_col(input logic [M*N-1:0] d, input int j);
        logic [M-1:0] c;
        for (int i = 0; i < M; i++) begin
            c[i] = d[i*N + j];
        end
        return c;
    endfunction

    function automatic int blk_sum(input logic [M*N-1:0] d);
        int s = 0;
        logic signed [N-1:0] w;
        for (int i = 0; i < M; i++) begin
            w = d[i*N +: N];
            s += int'(w);
        end
        return s;
    endfunction

    task automatic push_block(input logic [M*N-1:0] d);
        col_t e;
        for (int j = N - 1; j >= 0; j--) begin
            e.data = exp_col(d, j);
            e.msb  = (j == N - 1);
            e.last = (j == 0);
            e.idx  = j;
            sb.push_back(e);
        end
        sum_q.push_back(blk_sum(d));
    endtask

    task automatic flush();
        sb.delete();
        sum_q.delete();
        acc = 0;
    endtask

    // One clock: settle, score the column about to transfer, record an
    // acceptance, then advance to 2 time units after the rising edge.
    task automatic tick();
        col_t e;
        #1;
        accepted = 1'b0;
        if (rst_n && col_valid && col_ready) begin
            chk("col_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("col_data", 32'(col_data), 32'(e.data));
                chk("col_msb", 32'(col_msb), 32'(e.msb));
                chk("col_last", 32'(col_last), 32'(e.last));
                if (e.msb) begin
                    acc = 0;
                    acc = 2 * acc - $countones(col_data);
                end else begin
                    acc = 2 * acc + $countones(col_data);
                end
                last_idx = e.idx;
                if (e.last) begin
                    chk("recon_pending", 32'(sum_q.size() > 0), 32'd1);
                    if (sum_q.size() > 0) begin
                        chk("recon_sum", 32'(acc), 32'(sum_q.pop_front()));
                    end
                end
            end
        end else if (!col_valid) begin
            chk("idle_zero", 32'({col_msb, col_last, col_data}), 32'd0);
        end
        if (rst_n && blk_valid && blk_ready) begin
            push_block(blk_data);
            accepted = 1'b1;
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [M*N-1:0] d;
        logic [M*N-1:0] d2;
        int             cycles;
        int             v;

        rst_n     = 1'b0;
        blk_valid = 1'b0;
        col_ready = 1'b1;
        blk_data  = '0;

        // Reset state
        tick();
        chk("rst_blk_ready", 32'(blk_ready), 32'd0);
        chk("rst_col_valid", 32'(col_valid), 32'd0);
        chk("rst_col_data", 32'(col_data), 32'd0);
        chk("rst_flags", 32'({col_msb, col_last}), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_blk_ready", 32'(blk_ready), 32'd1);
        tick();

        // All words 0x80: only the sign column is set
        for (int i = 0; i < M; i++) blk_data[i*N +: N] = 8'h80;
        blk_valid = 1'b1;
        tick();
        chk("t1_accepted", 32'(accepted), 32'd1);
        blk_valid = 1'b0;
        chk("t1_first_valid", 32'(col_valid), 32'd1);
        chk("t1_first_msb", 32'(col_msb), 32'd1);
        chk("t1_first_data", 32'(col_data), 32'h0000FFFF);
        repeat (8) tick();
        chk("t1_done_valid", 32'(col_valid), 32'd0);

        // Word0 = 1: only column 0 lane 0 is set
        blk_data  = '0;
        blk_data[N-1:0] = 8'h01;
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        repeat (7) tick();
        chk("t2_last_valid", 32'(col_valid), 32'd1);
        chk("t2_last_flag", 32'(col_last), 32'd1);
        chk("t2_last_data", 32'(col_data), 32'h00000001);
        tick();
        chk("t2_valid_drop", 32'(col_valid), 32'd0);

        // Back-pressure on column 5 for three cycles
        for (int i = 0; i < M; i++) d[i*N +: N] = N'(i * 37 + 5);
        blk_data  = d;
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        tick();
        tick();
        chk("t3_col5", 32'(col_data), 32'(exp_col(d, 5)));
        col_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_hold_data", 32'(col_data), 32'(exp_col(d, 5)));
            chk("t3_hold_flags", 32'({col_valid, col_msb, col_last}), 32'b100);
            chk("t3_hold_ready", 32'(blk_ready), 32'd0);
        end
        col_ready = 1'b1;
        repeat (6) tick();
        chk("t3_done_valid", 32'(col_valid), 32'd0);
        chk("t3_all_cols", 32'(sb.size()), 32'd0);

        // Two blocks streamed back to back
        for (int i = 0; i < M; i++) begin
            d[i*N +: N]  = N'(i * 11 + 200);
            d2[i*N +: N] = N'(i * 29 + 7);
        end
        blk_data  = d;
        blk_valid = 1'b1;
        tick();
        blk_data = d2;
        for (int k = 0; k < 16; k++) begin
            chk("t4_stream_valid", 32'(col_valid), 32'd1);
            if (k == 7) chk("t4_first_last", 32'(col_last), 32'd1);
            if (k == 8) chk("t4_second_msb", 32'(col_msb), 32'd1);
            tick();
            if (k == 7) begin
                chk("t4_second_accepted", 32'(accepted), 32'd1);
                blk_valid = 1'b0;
            end
        end
        chk("t4_done_valid", 32'(col_valid), 32'd0);

        // Reset pulse after column 3 discards the block
        for (int i = 0; i < M; i++) d[i*N +: N] = N'(i * 53 + 91);
        blk_data  = d;
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        repeat (5) tick();
        chk("t5_col3_done", 32'(last_idx), 32'd3);
        rst_n = 1'b0;
        flush();
        tick();
        rst_n = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(col_valid), 32'd0);
        chk("t5_rst_data", 32'(col_data), 32'd0);
        chk("t5_rst_flags", 32'({col_msb, col_last}), 32'd0);
        chk("t5_rst_ready", 32'(blk_ready), 32'd1);
        for (int i = 0; i < M; i++) d[i*N +: N] = N'(i * 3 + 130);
        blk_data  = d;
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        chk("t5_restart_msb", 32'(col_msb), 32'd1);
        chk("t5_restart_data", 32'(col_data), 32'(exp_col(d, 7)));
        repeat (8) tick();
        chk("t5_done_valid", 32'(col_valid), 32'd0);

        // Random signed words -5..+7 with random back-pressure
        for (int b = 0; b < 1000; b++) begin
            for (int i = 0; i < M; i++) begin
                v = int'($urandom_range(12, 0)) - 5;
                d[i*N +: N] = N'(v);
            end
            blk_data  = d;
            blk_valid = 1'b1;
            cycles    = 0;
            do begin
                col_ready = ($urandom_range(3, 0) != 0);
                tick();
                cycles++;
            end while (!accepted && cycles < 200);
            chk("rand_accept", 32'(accepted), 32'd1);
            blk_valid = 1'b0;
        end
        cycles = 0;
        while (sb.size() > 0 && cycles < 400) begin
            col_ready = ($urandom_range(3, 0) != 0);
            tick();
            cycles++;
        end
        chk("drain_cols", 32'(sb.size()), 32'd0);
        chk("drain_sums", 32'(sum_q.size()), 32'd0);
        col_ready = 1'b1;
        tick();
        chk("final_idle", 32'(col_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
